// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder:
// response word type, FSM states, wait-counter width and fault NOP.
package imem_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP_INSTR  = 32'h0000_0013;
  localparam int    WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when any byte-address bit above the word-index field is set.
  function automatic logic addr_out_of_range(input word_t addr, input int aw);
    return (addr >> (aw + 2)) != '0;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response bundle between the core (master) and the
// instruction-memory responder (slave).
interface imem_responder_if;
  import imem_pkg::*;

  word_t iaddr_in;
  logic  ireq_in;
  logic  iready_o;
  logic  instr_rdy_in;
  word_t instr_o;
  logic  instr_vld_o;
  logic  misaligned_o;
  logic  addr_err_o;

  modport master (
    output iaddr_in, ireq_in, instr_rdy_in,
    input  iready_o, instr_o, instr_vld_o, misaligned_o, addr_err_o
  );

  modport slave (
    input  iaddr_in, ireq_in, instr_rdy_in,
    output iready_o, instr_o, instr_vld_o, misaligned_o, addr_err_o
  );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, asynchronous read, never cleared.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk_in,
  input  logic          we_in,
  input  logic [AW-1:0] waddr_in,
  input  word_t         wdata_in,
  input  logic [AW-1:0] raddr_in,
  output word_t         rdata_o
);

  word_t mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_in) begin
    if (we_in) begin
      mem_q[waddr_in] <= wdata_in;
    end
  end

  assign rdata_o = mem_q[raddr_in];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder: accepts one request in IDLE,
// waits WAIT_STATES cycles, then holds a registered response until taken.
module imem_responder
  import imem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_STATES = 2,
  parameter word_t NOP_INSTR   = imem_pkg::NOP_INSTR,
  localparam int   AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  imem_responder_if.slave         bus,
  input  logic                    ld_we_in,
  input  logic [AW-1:0]           ld_addr_in,
  input  word_t                   ld_data_in
);

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  word_t                 addr_q, addr_d;
  word_t                 instr_q, instr_d;
  logic                  vld_q, vld_d;
  logic                  mis_q, mis_d;
  logic                  err_q, err_d;
  logic                  iready_q, iready_d;

  word_t fetch_addr;
  word_t rd_data;
  logic  fetch_mis;
  logic  fetch_err;
  logic  enter_resp;

  // With zero wait states the response is built in the accept cycle, before
  // the address has been captured, so the live request address is used then.
  assign fetch_addr = (state_q == IDLE) ? bus.iaddr_in : addr_q;
  assign fetch_mis  = (fetch_addr[1:0] != 2'b00);
  assign fetch_err  = addr_out_of_range(fetch_addr, AW);

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_in   (clk_in),
    .we_in    (ld_we_in),
    .waddr_in (ld_addr_in),
    .wdata_in (ld_data_in),
    .raddr_in (fetch_addr[AW+1:2]),
    .rdata_o  (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    vld_d      = vld_q;
    mis_d      = mis_q;
    err_d      = err_q;
    iready_d   = iready_q;
    enter_resp = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ireq_in) begin
          addr_d   = bus.iaddr_in;
          iready_d = 1'b0;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.instr_rdy_in) begin
          state_d  = IDLE;
          vld_d    = 1'b0;
          iready_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        vld_d    = 1'b0;
        iready_d = 1'b1;
      end
    endcase

    // A load write landing on this same edge is not seen: rd_data is pre-edge.
    if (enter_resp) begin
      vld_d   = 1'b1;
      mis_d   = fetch_mis;
      err_d   = fetch_err;
      instr_d = (fetch_mis || fetch_err) ? NOP_INSTR : rd_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      instr_q  <= '0;
      vld_q    <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      iready_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      vld_q    <= vld_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
      iready_q <= iready_d;
    end
  end

  assign bus.iready_o     = iready_q;
  assign bus.instr_o      = instr_q;
  assign bus.instr_vld_o  = vld_q;
  assign bus.misaligned_o = mis_q;
  assign bus.addr_err_o   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: dut_a has two wait states, dut_b none; table of fetches
// plus hand sequences for stall, reset-in-WAIT and load/fetch collision.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_responder_if a_if ();
  imem_responder_if b_if ();

  logic          a_ld_we, b_ld_we;
  logic [AW-1:0] a_ld_addr, b_ld_addr;
  logic [31:0]   a_ld_data, b_ld_data;

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut_a (
    .clk_in     (clk),
    .rst_in     (rst_n),
    .bus        (a_if.slave),
    .ld_we_in   (a_ld_we),
    .ld_addr_in (a_ld_addr),
    .ld_data_in (a_ld_data)
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_b (
    .clk_in     (clk),
    .rst_in     (rst_n),
    .bus        (b_if.slave),
    .ld_we_in   (b_ld_we),
    .ld_addr_in (b_ld_addr),
    .ld_data_in (b_ld_data)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        mis;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input int idx, input logic [31:0] d);
    a_ld_we = 1'b1; a_ld_addr = AW'(idx); a_ld_data = d;
    tick();
    a_ld_we = 1'b0;
  endtask

  task automatic load_b(input int idx, input logic [31:0] d);
    b_ld_we = 1'b1; b_ld_addr = AW'(idx); b_ld_data = d;
    tick();
    b_ld_we = 1'b0;
  endtask

  // Single fetch on dut_a with instr_rdy_in high; lat counts edges from accept.
  task automatic fetch_a(input logic [31:0] addr, output logic [31:0] ins,
                         output logic mis, output logic err, output int lat);
    a_if.iaddr_in = addr; a_if.ireq_in = 1'b1; a_if.instr_rdy_in = 1'b1;
    tick();
    a_if.ireq_in = 1'b0; a_if.iaddr_in = 32'hFFFF_FFFF;
    lat = 1;
    while (a_if.instr_vld_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    ins = a_if.instr_o; mis = a_if.misaligned_o; err = a_if.addr_err_o;
    tick();
  endtask

  initial begin
    logic [31:0] ins;
    logic        mis, err, seen;
    int          lat;

    a_if.iaddr_in = '0; a_if.ireq_in = 1'b0; a_if.instr_rdy_in = 1'b0;
    b_if.iaddr_in = '0; b_if.ireq_in = 1'b0; b_if.instr_rdy_in = 1'b0;
    a_ld_we = 1'b0; a_ld_addr = '0; a_ld_data = '0;
    b_ld_we = 1'b0; b_ld_addr = '0; b_ld_data = '0;

    vecs[0] = '{32'h0000_0010, 32'h0010_0093, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h1111_1111, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0004, 32'h2222_2222, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0006, 32'h0000_0013, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_1000, 32'h0000_0013, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_1002, 32'h0000_0013, 1'b1, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'h0000_0013, 1'b0, 1'b1};

    // Reset, with a load performed while reset is held.
    tick();
    load_a(4, 32'h0010_0093);
    tick();
    chk("rst_a_vld", a_if.instr_vld_o, 1'b0);
    chk("rst_a_instr", a_if.instr_o, 32'h0);
    chk("rst_a_mis", a_if.misaligned_o, 1'b0);
    chk("rst_a_err", a_if.addr_err_o, 1'b0);
    chk("rst_a_iready", a_if.iready_o, 1'b1);
    chk("rst_b_vld", b_if.instr_vld_o, 1'b0);
    chk("rst_b_iready", b_if.iready_o, 1'b1);
    rst_n = 1'b1;
    tick();

    load_a(0, 32'h1111_1111);
    load_a(1, 32'h2222_2222);
    load_a(1023, 32'hDEAD_BEEF);
    load_a(8, 32'hAAAA_0001);
    load_b(0, 32'hA0A0_A0A0);
    load_b(1, 32'hB1B1_B1B1);

    for (int i = 0; i < 8; i++) begin
      fetch_a(vecs[i].addr, ins, mis, err, lat);
      chk($sformatf("v%0d_lat", i), lat, 3);
      chk($sformatf("v%0d_instr", i), ins, vecs[i].instr);
      chk($sformatf("v%0d_mis", i), mis, vecs[i].mis);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_idle", i), a_if.iready_o, 1'b1);
    end

    // Stall in RESP for 5 cycles with ireq_in held high (must be ignored).
    a_if.iaddr_in = 32'h4; a_if.ireq_in = 1'b1; a_if.instr_rdy_in = 1'b0;
    tick();
    a_if.iaddr_in = 32'h0;
    lat = 1;
    while (a_if.instr_vld_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("stall_lat", lat, 3);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_vld", k), a_if.instr_vld_o, 1'b1);
      chk($sformatf("stall%0d_instr", k), a_if.instr_o, 32'h2222_2222);
      chk($sformatf("stall%0d_iready", k), a_if.iready_o, 1'b0);
      tick();
    end
    a_if.instr_rdy_in = 1'b1;
    tick();
    a_if.ireq_in = 1'b0; a_if.instr_rdy_in = 1'b0;
    chk("stall_done_vld", a_if.instr_vld_o, 1'b0);
    chk("stall_done_iready", a_if.iready_o, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen = seen | a_if.instr_vld_o;
    end
    chk("stall_no_extra_vld", seen, 1'b0);

    // Reset while in WAIT discards the fetch.
    a_if.iaddr_in = 32'h10; a_if.ireq_in = 1'b1; a_if.instr_rdy_in = 1'b1;
    tick();
    a_if.ireq_in = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("wrst_vld", a_if.instr_vld_o, 1'b0);
    chk("wrst_instr", a_if.instr_o, 32'h0);
    chk("wrst_mis", a_if.misaligned_o, 1'b0);
    chk("wrst_err", a_if.addr_err_o, 1'b0);
    chk("wrst_iready", a_if.iready_o, 1'b1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | a_if.instr_vld_o;
    end
    chk("wrst_no_late_vld", seen, 1'b0);
    fetch_a(32'h10, ins, mis, err, lat);
    chk("wrst_mem_intact", ins, 32'h0010_0093);

    // Load write on the RESP-entry edge: old data is returned.
    a_if.iaddr_in = 32'h20; a_if.ireq_in = 1'b1; a_if.instr_rdy_in = 1'b1;
    tick();
    a_if.ireq_in = 1'b0;
    tick();
    a_ld_we = 1'b1; a_ld_addr = AW'(8); a_ld_data = 32'hBBBB_0002;
    tick();
    a_ld_we = 1'b0;
    chk("coll_same_vld", a_if.instr_vld_o, 1'b1);
    chk("coll_same_instr", a_if.instr_o, 32'hAAAA_0001);
    tick();

    // Load write one cycle earlier: new data is returned.
    a_if.ireq_in = 1'b1;
    tick();
    a_if.ireq_in = 1'b0;
    a_ld_we = 1'b1; a_ld_addr = AW'(8); a_ld_data = 32'hCCCC_0003;
    tick();
    a_ld_we = 1'b0;
    tick();
    chk("coll_early_vld", a_if.instr_vld_o, 1'b1);
    chk("coll_early_instr", a_if.instr_o, 32'hCCCC_0003);
    tick();

    // Zero wait states: back-to-back requests with instr_rdy_in high.
    b_if.iaddr_in = 32'h0; b_if.ireq_in = 1'b1; b_if.instr_rdy_in = 1'b1;
    tick();
    chk("b0_vld", b_if.instr_vld_o, 1'b1);
    chk("b0_instr", b_if.instr_o, 32'hA0A0_A0A0);
    chk("b0_iready", b_if.iready_o, 1'b0);
    b_if.iaddr_in = 32'h4;
    tick();
    chk("b0_done_vld", b_if.instr_vld_o, 1'b0);
    chk("b0_done_iready", b_if.iready_o, 1'b1);
    tick();
    chk("b1_vld", b_if.instr_vld_o, 1'b1);
    chk("b1_instr", b_if.instr_o, 32'hB1B1_B1B1);
    chk("b1_iready", b_if.iready_o, 1'b0);
    b_if.ireq_in = 1'b0;
    tick();
    chk("b1_done_vld", b_if.instr_vld_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: instruction words stored; power of two.
REQ-002 Parameter WAIT_STATES, default 2: extra cycles between request accept and response; range 0..15.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013: word returned on any faulted fetch.
REQ-004 clk_in  input  1  single clock; all state changes on rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-low.
REQ-006 iaddr_in  input  32  fetch byte address from the PC mux.
REQ-007 ireq_in  input  1  fetch request valid.
REQ-008 iready_o  output  1  responder can accept a request this cycle.
REQ-009 instr_rdy_in  input  1  core can take the response this cycle.
REQ-010 instr_o  output  32  fetched instruction.
REQ-011 instr_vld_o  output  1  instr_o valid.
REQ-012 misaligned_o  output  1  response faulted: iaddr_in[1:0] != 2'b00.
REQ-013 addr_err_o  output  1  response faulted: word index >= DEPTH_WORDS.
REQ-014 ld_we_in  input  1  program-load write enable.
REQ-015 ld_addr_in  input  log2(DEPTH_WORDS)  program-load word index.
REQ-016 ld_data_in  input  32  program-load data.

Function
REQ-017 FSM states IDLE, WAIT, RESP; iready_o high only in IDLE; instr_vld_o high only in RESP.
REQ-018 IDLE: ireq_in high captures iaddr_in; next state WAIT with counter = WAIT_STATES-1 if WAIT_STATES > 0, else RESP.
REQ-019 WAIT: counter decrements each cycle; leaves for RESP on the cycle it reads 0.
REQ-020 Latency: request accepted in cycle N; instr_vld_o first high in cycle N+1+WAIT_STATES.
REQ-021 Response registered on entry to RESP from the captured address; instr_o, misaligned_o, addr_err_o held stable while in RESP.
REQ-022 RESP: instr_rdy_in high completes the transfer; next state IDLE; no new request accepted in the completing cycle.
REQ-023 RESP with instr_rdy_in low: remain in RESP indefinitely; outputs unchanged.
REQ-024 Word index = captured address [31:2]; bits above log2(DEPTH_WORDS)+1 nonzero -> addr_err_o = 1.
REQ-025 Faulted response (misaligned or addr_err): instr_o = NOP_INSTR; both flags may assert together; latency unchanged.
REQ-026 ld_we_in writes ld_data_in at ld_addr_in on the clock edge, in any state.
REQ-027 Load write to the fetched word in the same cycle as RESP entry: response carries old data; writes in earlier cycles are visible.
REQ-028 ireq_in outside IDLE ignored; iaddr_in sampled only on acceptance.

Reset
REQ-029 rst_in low at a rising edge: state IDLE, counter 0, instr_o 32'h0, instr_vld_o 0, misaligned_o 0, addr_err_o 0.
REQ-030 Reset in WAIT or RESP discards the pending fetch; no response is produced for it.
REQ-031 Storage contents are not cleared by reset; load writes during reset are still performed.

Structure
REQ-032 Package imem_pkg holds NOP_INSTR, the FSM state enum, and the wait-counter width constant.
REQ-033 Storage is sub-module imem_array: DEPTH_WORDS x 32, synchronous write, asynchronous read.
REQ-034 imem_responder contains the FSM, wait counter, address capture, fault checks, and response registers.

Verification
REQ-035 WAIT_STATES=2; load word 4 = 32'h0010_0093; request 0x10 in cycle 5 -> instr_vld_o in cycle 8, instr_o = 32'h0010_0093, flags 0.
REQ-036 WAIT_STATES=0; requests 0x0 then 0x4, instr_rdy_in always high -> each valid one cycle after accept; iready_o low during RESP.
REQ-037 Request 0x6 -> instr_o = 32'h0000_0013, misaligned_o = 1; request 0x1000 with DEPTH_WORDS=1024 -> addr_err_o = 1, instr_o = NOP.
REQ-038 instr_rdy_in held low 5 cycles in RESP -> outputs stable for all 5; completion 1 cycle after instr_rdy_in rises; IDLE next.
REQ-039 rst_in low during WAIT -> next cycle all outputs 0, iready_o = 1; no late instr_vld_o; storage contents intact.
REQ-040 Load write to fetched word in RESP-entry cycle -> old data returned; rerun with write one cycle earlier -> new data returned.
